// File: rtl/shift_reduce_pkg.sv
// shift_reduce_pkg: shared mode and FSM state types for the shift-reduction engine
package shift_reduce_pkg;
  typedef enum logic [1:0] {SHL, SHR, SAR, ROL} shr_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} shr_state_e;
endpackage

// File: rtl/shift_reduce_step.sv
// shift_reduce_step: applies one chunk's unsigned shift amount to the accumulator in the given mode
module shift_reduce_step
  import shift_reduce_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] amt,
  input  shr_mode_e    mode,
  output logic [W-1:0] res
);
  logic [W-1:0]   rot;
  logic [W-1:0]   sar;
  logic [2*W-1:0] dbl;
  // Logical shifts by >= W already yield zero and >>> fills with the sign bit;
  // rotation reduces the amount mod W and takes the upper half of the doubled word.
  always_comb begin
    rot = W'(32'(amt) % W);
    dbl = {acc, acc} << rot;
    sar = $signed(acc) >>> amt;
    res = mode == SHL ? acc << amt :
          mode == SHR ? acc >> amt :
          mode == SAR ? sar : dbl[2*W-1:W];
  end
endmodule

// File: rtl/shift_reduce_seq.sv
// shift_reduce_seq: sequential fold of N shift-amount chunks into a W-bit accumulator, LANES chunks per cycle
module shift_reduce_seq
  import shift_reduce_pkg::*;
#(
  parameter int W     = 10,
  parameter int N     = 48,
  parameter int LANES = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_init,
  input  logic [N*W-1:0] in_data,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           busy
);
  localparam int STEPS = N / LANES;
  localparam int CW    = $clog2(STEPS + 1);
  if (N % LANES != 0) begin : g_lanes_check
    $error("shift_reduce_seq: N must be a multiple of LANES");
  end
  shr_state_e     state, state_nx;
  shr_mode_e      mode_q;
  logic [CW-1:0]  cnt;
  logic [N*W-1:0] data_q;
  logic [W-1:0]   acc;
  logic [W-1:0]   chain [LANES+1];
  logic           accept, last;
  assign chain[0] = acc;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    shift_reduce_step #(.W(W)) u_step (
      .acc  (chain[i]),
      .amt  (data_q[i*W +: W]),
      .mode (mode_q),
      .res  (chain[i+1])
    );
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state: accept only from IDLE, finish after the last step, release on consumer handshake
  always_comb begin
    accept   = in_valid & (state == IDLE);
    last     = cnt == CW'(STEPS - 1);
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  // datapath: captured chunks shift down so the active lanes always read the low slices
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      data_q   <= '0;
      mode_q   <= SHL;
      out_data <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= in_init;
      data_q <= in_data;
      mode_q <= shr_mode_e'(in_mode);
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      acc    <= chain[LANES];
      data_q <= data_q >> (LANES * W);
      if (last) out_data <= chain[LANES];
    end
  end
endmodule

// File: tb/tb_shift_reduce_seq.sv
// tb_shift_reduce_seq: directed vectors against LANES=1 and LANES=4 engines with a cycle-level reference model
module tb_shift_reduce_seq;
  import shift_reduce_pkg::*;
  localparam int W = 10;
  localparam int N = 48;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready;
  logic [W-1:0]   in_init;
  logic [N*W-1:0] in_data;
  logic [1:0]     in_mode;
  logic           in_ready_a, out_valid_a, busy_a;
  logic           in_ready_b, out_valid_b, busy_b;
  logic [W-1:0]   out_data_a, out_data_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shift_reduce_seq #(.W(W), .N(N), .LANES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_init(in_init), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a)
  );

  shift_reduce_seq #(.W(W), .N(N), .LANES(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_init(in_init), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference fold: one bit position per elementary step, amounts applied literally
  function automatic logic [W-1:0] fold(input logic [W-1:0] init, input logic [N*W-1:0] data,
                                        input logic [1:0] mode);
    logic [W-1:0] acc;
    int a;
    acc = init;
    for (int k = 0; k < N; k++) begin
      a = int'(data[k*W +: W]);
      case (mode)
        2'd0: for (int j = 0; j < a && j < W; j++) acc = {acc[W-2:0], 1'b0};
        2'd1: for (int j = 0; j < a && j < W; j++) acc = {1'b0, acc[W-1:1]};
        2'd2: for (int j = 0; j < a && j < W; j++) acc = {acc[W-1], acc[W-1:1]};
        default: for (int j = 0; j < a % W; j++) acc = {acc[W-2:0], acc[W-1]};
      endcase
    end
    return acc;
  endfunction

  function automatic logic [N*W-1:0] mk(input int c0, input int c1, input int c2);
    logic [N*W-1:0] d;
    d = '0;
    d[0 +: W]   = W'(c0);
    d[W +: W]   = W'(c1);
    d[2*W +: W] = W'(c2);
    return d;
  endfunction

  // Cycle-level model per engine: idle / counting down N/LANES cycles / holding result
  bit           m_busy  [2];
  bit           m_valid [2];
  int           m_cnt   [2];
  logic [W-1:0] m_res   [2];
  logic [W-1:0] m_data  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_valid[d] = 1'b0; m_cnt[d] = 0; m_res[d] = '0; m_data[d] = '0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0; m_valid[d] = 1'b0; m_data[d] = '0;
      end else if (!m_busy[d]) begin
        if (in_valid) begin
          m_busy[d] = 1'b1;
          m_cnt[d]  = d == 0 ? N : N / 4;
          m_res[d]  = fold(in_init, in_data, in_mode);
        end
      end else if (!m_valid[d]) begin
        m_cnt[d]--;
        if (m_cnt[d] == 0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = m_res[d];
        end
      end else if (out_ready) begin
        m_valid[d] = 1'b0; m_busy[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a in_ready", in_ready_a, !m_busy[0]);
      chk("a busy", busy_a, m_busy[0]);
      chk("a out_valid", out_valid_a, m_valid[0]);
      chk("a out_data", out_data_a, m_data[0]);
      chk("b in_ready", in_ready_b, !m_busy[1]);
      chk("b busy", busy_b, m_busy[1]);
      chk("b out_valid", out_valid_b, m_valid[1]);
      chk("b out_data", out_data_b, m_data[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [W-1:0] init, input logic [N*W-1:0] data,
                     input logic [1:0] mode, input logic [W-1:0] exp);
    int lat [2];
    logic [W-1:0] got [2];
    lat = '{0, 0};
    got = '{'0, '0};
    in_init = init; in_data = data; in_mode = mode; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 60 && (lat[0] == 0 || lat[1] == 0); k++) begin
      if (out_valid_a && lat[0] == 0) begin lat[0] = k; got[0] = out_data_a; end
      if (out_valid_b && lat[1] == 0) begin lat[1] = k; got[1] = out_data_b; end
      step();
    end
    chk({name, " lanes1 latency"}, lat[0], 49);
    chk({name, " lanes4 latency"}, lat[1], 13);
    chk({name, " lanes1 result"}, got[0], exp);
    chk({name, " lanes4 result"}, got[1], exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_init = '0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", in_ready_a, 1);
    chk("reset out_valid", out_valid_a, 0);
    chk("reset out_data", out_data_a, 0);
    chk("reset busy", busy_a, 0);
    chk_en = 1'b1;
    step();

    run("shl3", 10'h001, mk(3, 0, 0), 2'd0, 10'h008);
    run("shl15", 10'h001, mk(15, 0, 0), 2'd0, 10'h000);
    run("sar2", 10'h200, mk(2, 0, 0), 2'd2, 10'h380);
    run("rol1_11", 10'h201, mk(1, 11, 0), 2'd3, 10'h006);
    run("shr4", 10'h3FF, mk(4, 0, 0), 2'd1, 10'h03F);
    run("shr10", 10'h3FF, mk(10, 0, 0), 2'd1, 10'h000);
    run("sar20neg", 10'h200, mk(20, 0, 0), 2'd2, 10'h3FF);
    run("sar20pos", 10'h100, mk(20, 0, 0), 2'd2, 10'h000);
    run("shl123", 10'h001, mk(1, 2, 3), 2'd0, 10'h040);
    run("rol1023", 10'h001, mk(1023, 0, 0), 2'd3, 10'h008);
    run("shl_init0", 10'h000, mk(5, 7, 9), 2'd0, 10'h000);

    out_ready = 1'b0;
    in_init = 10'h001; in_data = mk(3, 0, 0); in_mode = 2'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && !out_valid_a; k++) step();
    chk("bp reached done", out_valid_a, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_init = 10'h3FF; in_mode = 2'd1;
      chk("bp hold valid", out_valid_a, 1);
      chk("bp hold data", out_data_a, 10'h008);
      chk("bp in_ready low", in_ready_a, 0);
      chk("bp lanes4 data", out_data_b, 10'h008);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp release idle", in_ready_a, 1);
    chk("bp release valid", out_valid_a, 0);
    chk("bp data kept", out_data_a, 10'h008);

    in_init = 10'h200; in_data = mk(2, 0, 0); in_mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort idle", in_ready_a, 1);
    chk("abort valid", out_valid_a, 0);
    chk("abort busy", busy_a, 0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid_a) seen = 1;
      step();
    end
    chk("abort never valid", seen, 0);
    run("after_abort", 10'h001, mk(3, 0, 0), 2'd0, 10'h008);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
